imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Front-end block upstream of the five-stage core. Receives a byte-serial program image over a valid/ready stream and writes it word-by-word into instruction memory.
- Holds the core in reset until the image is complete and its checksum verifies, then releases it.
- Sits between the external byte source (UART or testbench) and the core's rst input and instruction memory write port.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity = 2^ADDR_W words.
- CORE_RST_HOLD, 4, cycles core_rst stays high after checksum pass before deasserting (min 1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins or restarts a load
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of write
- imem_wdata  out  32  word written
- core_rst  out  1  reset to core; high = core held in reset
- busy  out  1  high in LEN/DATA/CSUM/HOLD
- done  out  1  high in DONE
- err  out  1  high in ERR
- err_code  out  2  0 none, 1 length overflow, 2 checksum mismatch

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high.
- Reset: state IDLE. Outputs: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0, err_code=0.
- Byte accept = s_valid && s_ready. s_ready is 1 only in LEN, DATA and CSUM, and is not a function of s_valid.
- Image format, all little-endian: 4-byte word count N, then N words of 4 bytes each, then 1 checksum byte. Checksum = 8-bit wrap-around sum of all preceding bytes (length bytes included).
- IDLE: start -> LEN; clear byte counter, word counter and running sum; core_rst=1.
- LEN: accept 4 bytes into N.
  - On the 4th byte, if N > 2^ADDR_W -> ERR with err_code=1.
  - Else if N==0 -> CSUM.
  - Else -> DATA.
- DATA: assemble 4 bytes per word.
  - The cycle after the 4th byte is accepted: imem_we=1 for exactly one cycle, imem_addr = word index (0..N-1), imem_wdata = assembled word.
  - After word N-1 -> CSUM.
  - Back-to-back bytes at full rate must be sustained; the write pulse never stalls s_ready.
- CSUM: accept 1 byte.
  - Match -> HOLD.
  - Mismatch -> ERR with err_code=2.
- HOLD: core_rst stays 1 for CORE_RST_HOLD cycles, then -> DONE.
- DONE: core_rst=0, done=1; remains until start or rst.
- ERR: core_rst=1, err=1, err_code held; remains until start or rst.
- start in any state (including mid-load, DONE and ERR): next cycle is LEN, counters and sum are cleared, core_rst=1, err/err_code/done cleared. A byte presented in the same cycle as start is not accepted.
- rst mid-load: returns to IDLE; a pending imem_we is suppressed.
- Word address counter is ADDR_W+1 bits internally so N = 2^ADDR_W is legal without wrap; imem_addr is the low ADDR_W bits.
- No write occurs for any byte after the checksum; extra stream bytes are left unaccepted.

Decomposition:
- Shared header boot_loader_defs: state encodings (IDLE, LEN, DATA, CSUM, HOLD, DONE, ERR) and err_code constants.
- Sub-module byte_word_packer:
  - Inputs: byte accept, byte, clear.
  - Outputs: 32-bit word, one-cycle word_valid.
  - Reused for both the length field and the payload words.
- Top module holds the FSM, word counter, checksum accumulator and hold counter.

Test Plan:
- Single NOP: start, bytes 01 00 00 00 13 00 00 00 14 -> one write addr 0 data 0x00000013; after 4 hold cycles done=1, core_rst=0.
- Three words with s_valid toggling every other cycle -> writes at addr 0,1,2 with correct data and exactly one imem_we per word; checksum pass -> done=1.
- Bad checksum: same image as the NOP case, last byte 0x15 -> err=1, err_code=2, core_rst stays 1, s_ready=0 afterwards.
- Overflow: ADDR_W=2, N=5 (05 00 00 00) -> ERR, err_code=1 immediately after the 4th length byte; no imem_we ever.
- N=0: bytes 00 00 00 00 00 -> no writes, done=1.
- Restart: start pulse after 6 bytes of a load, then a full valid image -> writes begin again at addr 0; in a separate run, rst mid-DATA -> IDLE, core_rst=1, no stray write.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader_pkg
// Purpose  : Shared state encoding, error codes and decode helpers for the loader.
// Revision : 1.0
// ============================================================================
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    localparam logic [1:0] c_err_none    = 2'd0;
    localparam logic [1:0] c_err_len_ovf = 2'd1;
    localparam logic [1:0] c_err_csum    = 2'd2;

    // Byte slot index that completes a little-endian 32-bit word.
    localparam logic [1:0] c_idx_last    = 2'd3;

    function automatic logic accepts_bytes(input state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    function automatic logic is_busy(input state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM) || (s == ST_HOLD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader_byte_word_packer
// Purpose  : Packs accepted bytes little-endian into 32-bit words.
// Revision : 1.0
// ============================================================================
module imem_boot_loader_byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [23:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            idx_q <= '0;
            lo_q  <= '0;
        end else if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    lo_q[7:0]   <= byte_i;
                2'd1:    lo_q[15:8]  <= byte_i;
                2'd2:    lo_q[23:16] <= byte_i;
                default: ;
            endcase
        end
    end

    // The top byte is passed straight through so the word is usable in the
    // same cycle its last byte is accepted.
    assign word_o       = {byte_i, lo_q};
    assign word_valid_o = byte_valid_i && (idx_q == c_idx_last);

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Loads a byte-serial, checksummed image into IMEM; gates core reset.
// Revision : 1.0
// ============================================================================
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int CORE_RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int                HOLD_W      = $clog2(CORE_RST_HOLD + 1);
    localparam logic [32:0]       c_capacity  = 33'(1) << ADDR_W;
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(CORE_RST_HOLD - 1);

    state_e              state_q,    state_d;
    logic [ADDR_W:0]     len_q,      len_d;
    logic [ADDR_W:0]     widx_q,     widx_d;
    logic [7:0]          sum_q,      sum_d;
    logic [HOLD_W-1:0]   hold_q,     hold_d;
    logic                we_q,       we_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                s_ready_q;
    logic                core_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                pk_byte_valid;
    logic [31:0]         pk_word;
    logic                pk_valid;
    logic [ADDR_W:0]     widx_inc;

    // A byte offered alongside start belongs to the abandoned load.
    assign s_ready       = s_ready_q & ~start;
    assign accept        = s_valid & s_ready;
    assign pk_byte_valid = accept && ((state_q == ST_LEN) || (state_q == ST_DATA));
    assign widx_inc      = widx_q + (ADDR_W + 1)'(1);

    imem_boot_loader_byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start),
        .byte_valid_i (pk_byte_valid),
        .byte_i       (s_data),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        widx_d     = widx_q;
        sum_d      = sum_q;
        hold_d     = hold_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        if (start) begin
            state_d    = ST_LEN;
            len_d      = '0;
            widx_d     = '0;
            sum_d      = '0;
            hold_d     = '0;
            err_code_d = c_err_none;
        end else begin
            case (state_q)
                ST_LEN: begin
                    if (accept) begin
                        sum_d = sum_q + s_data;
                        if (pk_valid) begin
                            if ({1'b0, pk_word} > c_capacity) begin
                                state_d    = ST_ERR;
                                err_code_d = c_err_len_ovf;
                            end else if (pk_word == 32'd0) begin
                                state_d = ST_CSUM;
                            end else begin
                                state_d = ST_DATA;
                                len_d   = pk_word[ADDR_W:0];
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        sum_d = sum_q + s_data;
                        if (pk_valid) begin
                            we_d    = 1'b1;
                            addr_d  = widx_q[ADDR_W-1:0];
                            wdata_d = pk_word;
                            widx_d  = widx_inc;
                            if (widx_inc == len_q) begin
                                state_d = ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (s_data == sum_q) begin
                            state_d = ST_HOLD;
                            hold_d  = '0;
                        end else begin
                            state_d    = ST_ERR;
                            err_code_d = c_err_csum;
                        end
                    end
                end
                ST_HOLD: begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_q == c_hold_last) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            widx_q     <= '0;
            sum_q      <= '0;
            hold_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= c_err_none;
            s_ready_q  <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            sum_q      <= sum_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
            s_ready_q  <= accepts_bytes(state_d);
            core_rst_q <= (state_d != ST_DONE);
            busy_q     <= is_busy(state_d);
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERR);
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed image loads checked every cycle against a byte-stream model.
// Revision : 1.0
// ============================================================================
module tb_imem_boot_loader;

    localparam int AW   = 2;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          rst, start, s_valid;
    logic [7:0]    s_data;
    logic          s_ready, imem_we, core_rst, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [1:0]    err_code;

    imem_boot_loader #(.ADDR_W(AW), .CORE_RST_HOLD(HOLD)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: everything is derived from the list of bytes accepted since start.
    bit          m_started, m_csum_ok, m_done;
    int          m_errc, m_hold, m_addr;
    bit          m_we;
    logic [31:0] m_wdata;
    logic [7:0]  m_bytes[$];

    function automatic logic [31:0] le_word(input int b);
        return {m_bytes[b+3], m_bytes[b+2], m_bytes[b+1], m_bytes[b]};
    endfunction

    function automatic bit exp_ready();
        return m_started && (m_errc == 0) && !m_csum_ok && !start;
    endfunction

    always @(posedge clk) begin : model
        bit         rdy;
        int         k;
        longint     n;
        logic [7:0] cs;
        rdy = exp_ready();
        if (rst) begin
            m_started = 0; m_csum_ok = 0; m_done = 0; m_errc = 0; m_hold = 0;
            m_we = 0; m_addr = 0; m_wdata = '0; m_bytes.delete();
        end else begin
            m_we = 0;
            if (start) begin
                m_started = 1; m_csum_ok = 0; m_done = 0; m_errc = 0; m_hold = 0;
                m_bytes.delete();
            end else if (m_csum_ok && !m_done) begin
                m_hold++;
                if (m_hold == HOLD) m_done = 1;
            end else if (rdy && s_valid) begin
                m_bytes.push_back(s_data);
                k = m_bytes.size();
                n = (k >= 4) ? longint'(le_word(0)) : 0;
                if (k == 4 && n > (longint'(1) << AW)) begin
                    m_errc = 1;
                end else if (k > 4 && k <= 4 + 4 * n && (k % 4) == 0) begin
                    m_we    = 1;
                    m_addr  = ((k / 4) - 2) % (1 << AW);
                    m_wdata = le_word(k - 4);
                end else if (k > 4 && k == 5 + 4 * n) begin
                    cs = 8'h00;
                    for (int i = 0; i < k - 1; i++) cs = cs + m_bytes[i];
                    if (cs == s_data) m_csum_ok = 1;
                    else m_errc = 2;
                end
            end
        end
    end

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready",    32'(s_ready),    32'(exp_ready()));
            chk("imem_we",    32'(imem_we),    32'(m_we));
            chk("imem_addr",  32'(imem_addr),  32'(m_addr));
            chk("imem_wdata", imem_wdata,      m_wdata);
            chk("core_rst",   32'(core_rst),   32'(!m_done));
            chk("busy",       32'(busy),       32'(m_started && m_errc == 0 && !m_done));
            chk("done",       32'(done),       32'(m_done));
            chk("err",        32'(err),        32'(m_errc != 0));
            chk("err_code",   32'(err_code),   32'(m_errc));
            if (imem_we === 1'b1) begin
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
            end
        end
    end

    logic [7:0] tx[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        r       = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 40 && !r; t++) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #2;
        end
        s_valid = 1'b0;
        chk("byte_accept_timeout", 32'(r), 32'd1);
    endtask

    task automatic send_tx(input int gap);
        foreach (tx[i]) begin
            send_byte(tx[i]);
            tick(gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clr_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        tick(2);
        chk("reset core_rst", 32'(core_rst), 32'd1);
        chk("reset s_ready",  32'(s_ready),  32'd0);
        rst = 1'b0;
        tick(2);

        // single NOP, full rate; then extra bytes must stay unaccepted
        clr_log(); pulse_start();
        tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        send_tx(0); tick(6);
        chk("nop writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("nop addr", 32'(wr_addr[0]), 32'd0);
            chk("nop data", wr_data[0], 32'h0000_0013);
        end
        chk("nop done",     32'(done),     32'd1);
        chk("nop core_rst", 32'(core_rst), 32'd0);
        s_valid = 1'b1; s_data = 8'h77; tick(3); s_valid = 1'b0;

        // three words, one idle cycle between bytes
        clr_log(); pulse_start();
        tx = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hF1};
        send_tx(1); tick(6);
        chk("3w writes", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("3w addr2", 32'(wr_addr[2]), 32'd2);
            chk("3w data1", wr_data[1], 32'h0010_0093);
            chk("3w data2", wr_data[2], 32'hDEAD_BEEF);
        end
        chk("3w done", 32'(done), 32'd1);

        // bad checksum
        clr_log(); pulse_start();
        tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h15};
        send_tx(0); tick(2);
        chk("csum err_code", 32'(err_code), 32'd2);
        chk("csum core_rst", 32'(core_rst), 32'd1);
        s_valid = 1'b1; s_data = 8'h14; tick(3); s_valid = 1'b0;

        // length overflow: N=5 with 4-word capacity
        clr_log(); pulse_start();
        tx = '{8'h05, 8'h00, 8'h00, 8'h00};
        send_tx(0);
        chk("ovf err",      32'(err),      32'd1);
        chk("ovf err_code", 32'(err_code), 32'd1);
        s_valid = 1'b1; s_data = 8'h00; tick(4); s_valid = 1'b0;
        chk("ovf writes", 32'(wr_addr.size()), 32'd0);

        // N at full capacity is legal
        clr_log(); pulse_start();
        tx = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0E};
        send_tx(0); tick(6);
        chk("cap writes", 32'(wr_addr.size()), 32'd4);
        if (wr_addr.size() == 4) begin
            chk("cap addr3", 32'(wr_addr[3]), 32'd3);
            chk("cap data3", wr_data[3], 32'h0000_0004);
        end
        chk("cap done", 32'(done), 32'd1);

        // empty image
        clr_log(); pulse_start();
        tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_tx(0); tick(6);
        chk("n0 writes", 32'(wr_addr.size()), 32'd0);
        chk("n0 done",   32'(done),           32'd1);

        // restart mid-load, with a byte offered in the start cycle
        clr_log(); pulse_start();
        tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
        send_tx(0);
        s_valid = 1'b1; s_data = 8'hAA; start = 1'b1;
        tick(1);
        start = 1'b0; s_valid = 1'b0;
        tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        send_tx(0); tick(6);
        chk("restart writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("restart addr", 32'(wr_addr[0]), 32'd0);
            chk("restart data", wr_data[0], 32'h0000_0013);
        end
        chk("restart done", 32'(done), 32'd1);

        // rst on the cycle that would complete the first word
        clr_log(); pulse_start();
        tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00};
        send_tx(0);
        s_valid = 1'b1; s_data = 8'h00; rst = 1'b1;
        tick(1);
        rst = 1'b0; s_valid = 1'b0;
        tick(3);
        chk("rst writes",   32'(wr_addr.size()), 32'd0);
        chk("rst core_rst", 32'(core_rst),       32'd1);
        chk("rst busy",     32'(busy),           32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
